// File: rtl/connect4_turn_ctrl_if.sv
// Connect4 turn sequencer bus: button pulses, win-checker handshake and board-write port.
// master drives buttons/checker results; slave is the sequencer.
interface connect4_turn_ctrl_if #(
   parameter int COLS = 7,
   parameter int ROWS = 6
);
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic          press_izq;
   logic          press_der;
   logic          press_ent;
   logic          check_done;
   logic          check_win;
   logic [CW-1:0] cursor_col;
   logic          player;
   logic          wr_en;
   logic [CW-1:0] wr_col;
   logic [RW-1:0] wr_row;
   logic          wr_player;
   logic          reject;
   logic          game_over;
   logic [1:0]    winner;
   logic          turn_timeout;

   modport master (
      output press_izq, press_der, press_ent, check_done, check_win,
      input  cursor_col, player, wr_en, wr_col, wr_row, wr_player,
             reject, game_over, winner, turn_timeout
   );

   modport slave (
      input  press_izq, press_der, press_ent, check_done, check_win,
      output cursor_col, player, wr_en, wr_col, wr_row, wr_player,
             reject, game_over, winner, turn_timeout
   );
endinterface

// File: rtl/connect4_turn_ctrl.sv
// Connect4 game sequencer: cursor, column drop, win-checker handshake, win/draw detection.
// Define TURN_TIMER_EN to add the per-turn timer that forces a drop after TURN_CYCLES cycles.
module connect4_turn_ctrl #(
   parameter int COLS        = 7,
   parameter int ROWS        = 6,
   parameter int TURN_CYCLES = 50000000
) (
   input logic                 clk,
   input logic                 reset_n,
   connect4_turn_ctrl_if.slave bus
);
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int HW = $clog2(ROWS + 1);
   localparam int MW = $clog2(ROWS * COLS + 1);

   localparam logic [1:0] SELECT    = 2'd0;
   localparam logic [1:0] DROP      = 2'd1;
   localparam logic [1:0] CHECK     = 2'd2;
   localparam logic [1:0] GAME_OVER = 2'd3;

   localparam logic [CW-1:0] CENTER    = CW'(COLS / 2);
   localparam logic [HW-1:0] FULL      = HW'(ROWS);
   localparam logic [MW-1:0] ALL_MOVES = MW'(ROWS * COLS);

   logic [1:0]    state;
   logic [CW-1:0] cursorCol;
   logic [CW-1:0] dropCol;
   logic [CW-1:0] forcedCol;
   logic [HW-1:0] heights [COLS];
   logic [MW-1:0] moveCount;
   logic          player;
   logic          rejectPulse;
   logic          timeoutPulse;
   logic          gameOver;
   logic [1:0]    winner;
   logic          timerExpire;

   function automatic logic [CW-1:0] wrapInc(input logic [CW-1:0] c);
      return (c == CW'(COLS - 1)) ? '0 : c + CW'(1);
   endfunction

   function automatic logic [CW-1:0] wrapDec(input logic [CW-1:0] c);
      return (c == '0) ? CW'(COLS - 1) : c - CW'(1);
   endfunction

`ifdef TURN_TIMER_EN
   localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

   logic [TW-1:0] turnCnt;
   logic          entSel;
   logic          found;
   int            idx;

   // Held at zero outside SELECT so every entry starts a fresh turn; saturates at the limit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         turnCnt <= '0;
      else if (state != SELECT)
         turnCnt <= '0;
      else if (turnCnt != TURN_LAST)
         turnCnt <= turnCnt + TW'(1);
   end

   assign entSel      = bus.press_ent & ~bus.press_izq & ~bus.press_der;
   assign timerExpire = (state == SELECT) && (turnCnt == TURN_LAST) && !entSel;

   // A board with a free cell always exists in SELECT, so the scan always finds a column
   always_comb begin
      forcedCol = cursorCol;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < COLS; i++) begin
         idx = (int'(cursorCol) + i) % COLS;
         if (!found && heights[idx] != FULL) begin
            forcedCol = CW'(idx);
            found     = 1'b1;
         end
      end
   end
`else
   // TURN_CYCLES is never negative, so this is a constant 0
   assign timerExpire = (TURN_CYCLES < 0);
   assign forcedCol   = '0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= SELECT;
         cursorCol    <= CENTER;
         dropCol      <= '0;
         player       <= 1'b0;
         moveCount    <= '0;
         rejectPulse  <= 1'b0;
         timeoutPulse <= 1'b0;
         gameOver     <= 1'b0;
         winner       <= 2'b00;
         for (int c = 0; c < COLS; c++) heights[c] <= '0;
      end else begin
         rejectPulse  <= 1'b0;
         timeoutPulse <= 1'b0;
         case (state)
            SELECT: begin
               if (timerExpire) begin
                  dropCol      <= forcedCol;
                  timeoutPulse <= 1'b1;
                  state        <= DROP;
               end else if (bus.press_izq) begin
                  cursorCol <= wrapDec(cursorCol);
               end else if (bus.press_der) begin
                  cursorCol <= wrapInc(cursorCol);
               end else if (bus.press_ent) begin
                  if (heights[cursorCol] == FULL) begin
                     rejectPulse <= 1'b1;
                  end else begin
                     dropCol <= cursorCol;
                     state   <= DROP;
                  end
               end
            end
            DROP: begin
               heights[dropCol] <= heights[dropCol] + HW'(1);
               moveCount        <= moveCount + MW'(1);
               state            <= CHECK;
            end
            CHECK: begin
               if (bus.check_done) begin
                  if (bus.check_win) begin
                     state    <= GAME_OVER;
                     gameOver <= 1'b1;
                     winner   <= player ? 2'b10 : 2'b01;
                  end else if (moveCount == ALL_MOVES) begin
                     state    <= GAME_OVER;
                     gameOver <= 1'b1;
                     winner   <= 2'b11;
                  end else begin
                     player <= ~player;
                     state  <= SELECT;
                  end
               end
            end
            GAME_OVER: begin
               if (bus.press_ent) begin
                  state     <= SELECT;
                  cursorCol <= CENTER;
                  player    <= 1'b0;
                  moveCount <= '0;
                  gameOver  <= 1'b0;
                  winner    <= 2'b00;
                  for (int c = 0; c < COLS; c++) heights[c] <= '0;
               end
            end
            default: state <= SELECT;
         endcase
      end
   end

   assign bus.cursor_col   = cursorCol;
   assign bus.player       = player;
   assign bus.wr_en        = (state == DROP);
   assign bus.wr_col       = (state == DROP) ? dropCol : '0;
   assign bus.wr_row       = (state == DROP) ? heights[dropCol][RW-1:0] : '0;
   assign bus.wr_player    = (state == DROP) & player;
   assign bus.reject       = rejectPulse;
   assign bus.game_over    = gameOver;
   assign bus.winner       = winner;
   assign bus.turn_timeout = timeoutPulse;
endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Self-checking bench for connect4_turn_ctrl against a board-level game model.
// Build with TURN_TIMER_EN defined to also exercise the forced-drop timer (TURN_CYCLES=16).
module tb_connect4_turn_ctrl;
   localparam int COLS = 7;
   localparam int ROWS = 6;
`ifdef TURN_TIMER_EN
   localparam int TC = 16;
`else
   localparam int TC = 50000000;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   // Game model: what a referee would track on paper
   int mCursor, mPlayer, mMoves, mWinner;
   int mH [COLS];
   bit mOver;

   connect4_turn_ctrl_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

   connect4_turn_ctrl #(.COLS(COLS), .ROWS(ROWS), .TURN_CYCLES(TC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic modelReset();
      mCursor = COLS / 2;
      mPlayer = 0;
      mMoves  = 0;
      mWinner = 0;
      mOver   = 1'b0;
      for (int c = 0; c < COLS; c++) mH[c] = 0;
   endtask

   task automatic cycle(input bit izq, input bit der, input bit ent, input bit done, input bit win);
      bus.press_izq  = izq;
      bus.press_der  = der;
      bus.press_ent  = ent;
      bus.check_done = done;
      bus.check_win  = win;
      @(posedge clk);
      #1;
      bus.press_izq  = 1'b0;
      bus.press_der  = 1'b0;
      bus.press_ent  = 1'b0;
      bus.check_done = 1'b0;
      bus.check_win  = 1'b0;
   endtask

   task automatic applyReset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
      modelReset();
   endtask

   task automatic moveTo(input int col);
      while (mCursor != col) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         mCursor = (mCursor + 1) % COLS;
         checks++;
         if (bus.cursor_col !== 3'(mCursor)) begin
            failures++;
            $display("FAIL move_cursor got=%0d exp=%0d", bus.cursor_col, mCursor);
         end
      end
   endtask

   function automatic int pickCol();
      int c;
      c = $urandom_range(0, COLS - 1);
      while (mH[c] >= ROWS) c = (c + 1) % COLS;
      return c;
   endfunction

   task automatic doMove(input int col, input bit win, input int delay);
      int row;
      moveTo(col);
      row = mH[col];
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({bus.wr_en, bus.wr_col, bus.wr_row, bus.wr_player} !== {1'b1, 3'(col), 3'(row), 1'(mPlayer)}) begin
         failures++;
         $display("FAIL drop_write got en=%0b col=%0d row=%0d pl=%0b exp en=1 col=%0d row=%0d pl=%0d",
                  bus.wr_en, bus.wr_col, bus.wr_row, bus.wr_player, col, row, mPlayer);
      end
      mH[col]++;
      mMoves++;
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int d = 0; d < delay; d++)
         cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      checks++;
      if (bus.wr_en !== 1'b0 || bus.cursor_col !== 3'(mCursor) || bus.player !== 1'(mPlayer)) begin
         failures++;
         $display("FAIL check_wait got en=%0b cur=%0d pl=%0b exp en=0 cur=%0d pl=%0d",
                  bus.wr_en, bus.cursor_col, bus.player, mCursor, mPlayer);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, win);
      if (win) begin
         mOver = 1'b1;
         mWinner = mPlayer + 1;
      end else if (mMoves == ROWS * COLS) begin
         mOver = 1'b1;
         mWinner = 3;
      end else begin
         mPlayer = 1 - mPlayer;
      end
      checks++;
      if ({bus.game_over, bus.winner, bus.player, bus.cursor_col} !==
          {1'(mOver), 2'(mWinner), 1'(mPlayer), 3'(mCursor)}) begin
         failures++;
         $display("FAIL after_check got go=%0b win=%0d pl=%0b cur=%0d exp go=%0d win=%0d pl=%0d cur=%0d",
                  bus.game_over, bus.winner, bus.player, bus.cursor_col, mOver, mWinner, mPlayer, mCursor);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      modelReset();
      checks++;
      if ({bus.cursor_col, bus.player, bus.winner, bus.game_over} !== {3'(mCursor), 1'b0, 2'b00, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got cur=%0d pl=%0b win=%0d go=%0b exp cur=3 pl=0 win=0 go=0",
                  bus.cursor_col, bus.player, bus.winner, bus.game_over);
      end
      checks++;
      if ({bus.wr_en, bus.reject, bus.turn_timeout, bus.wr_col, bus.wr_row, bus.wr_player} !== 10'd0) begin
         failures++;
         $display("FAIL reset_strobes got %b exp 0", {bus.wr_en, bus.reject, bus.turn_timeout,
                  bus.wr_col, bus.wr_row, bus.wr_player});
      end
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         mCursor = (mCursor + 1) % COLS;
         checks++;
         if (bus.cursor_col !== 3'(mCursor)) begin
            failures++;
            $display("FAIL der_wrap got=%0d exp=%0d", bus.cursor_col, mCursor);
         end
      end
   endtask

   task automatic test_cursor();
      bit izq, der;
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      mCursor = (mCursor + COLS - 1) % COLS;
      checks++;
      if (bus.cursor_col !== 3'(mCursor)) begin
         failures++;
         $display("FAIL izq_wrap got=%0d exp=%0d", bus.cursor_col, mCursor);
      end
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      mCursor = (mCursor + COLS - 1) % COLS;
      checks++;
      if (bus.cursor_col !== 3'(mCursor)) begin
         failures++;
         $display("FAIL izq_der_priority got=%0d exp=%0d", bus.cursor_col, mCursor);
      end
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      mCursor = (mCursor + COLS - 1) % COLS;
      checks++;
      if (bus.cursor_col !== 3'(mCursor) || bus.wr_en !== 1'b0 || bus.reject !== 1'b0) begin
         failures++;
         $display("FAIL izq_ent_priority got cur=%0d en=%0b rej=%0b exp cur=%0d en=0 rej=0",
                  bus.cursor_col, bus.wr_en, bus.reject, mCursor);
      end
      for (int i = 0; i < 3; i++) begin
         izq = 1'($urandom);
         der = 1'($urandom);
         cycle(izq, der, 1'b0, 1'b0, 1'b0);
         if (izq) mCursor = (mCursor + COLS - 1) % COLS;
         else if (der) mCursor = (mCursor + 1) % COLS;
         checks++;
         if (bus.cursor_col !== 3'(mCursor)) begin
            failures++;
            $display("FAIL random_cursor got=%0d exp=%0d", bus.cursor_col, mCursor);
         end
      end
   endtask

   task automatic test_drops();
      applyReset();
      doMove(3, 1'b0, 0);
      doMove(3, 1'b0, 0);
   endtask

   task automatic test_full_column();
      int pl;
      for (int i = 0; i < ROWS; i++) doMove(0, 1'b0, $urandom_range(0, 2));
      moveTo(0);
      pl = mPlayer;
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.reject !== 1'b1 || bus.wr_en !== 1'b0 || bus.player !== 1'(pl)) begin
         failures++;
         $display("FAIL full_reject got rej=%0b en=%0b pl=%0b exp rej=1 en=0 pl=%0d",
                  bus.reject, bus.wr_en, bus.player, pl);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.reject !== 1'b0 || bus.wr_en !== 1'b0) begin
         failures++;
         $display("FAIL reject_pulse got rej=%0b en=%0b exp rej=0 en=0", bus.reject, bus.wr_en);
      end
   endtask

   task automatic test_win();
      if (mPlayer == 0) doMove(pickCol(), 1'b0, 1);
      doMove(pickCol(), 1'b1, 1);
      checks++;
      if (bus.winner !== 2'b10 || bus.game_over !== 1'b1) begin
         failures++;
         $display("FAIL p1_win got win=%0d go=%0b exp win=2 go=1", bus.winner, bus.game_over);
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.cursor_col !== 3'(mCursor) || bus.game_over !== 1'b1 || bus.wr_en !== 1'b0) begin
         failures++;
         $display("FAIL over_ignore got cur=%0d go=%0b en=%0b exp cur=%0d go=1 en=0",
                  bus.cursor_col, bus.game_over, bus.wr_en, mCursor);
      end
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      modelReset();
      checks++;
      if ({bus.cursor_col, bus.player, bus.winner, bus.game_over} !== {3'(mCursor), 1'b0, 2'b00, 1'b0}) begin
         failures++;
         $display("FAIL restart got cur=%0d pl=%0b win=%0d go=%0b exp cur=%0d pl=0 win=0 go=0",
                  bus.cursor_col, bus.player, bus.winner, bus.game_over, mCursor);
      end
   endtask

   task automatic test_draw();
      for (int i = 0; i < ROWS * COLS; i++) doMove(pickCol(), 1'b0, $urandom_range(0, 2));
      checks++;
      if (bus.winner !== 2'b11 || bus.game_over !== 1'b1) begin
         failures++;
         $display("FAIL draw got win=%0d go=%0b exp win=3 go=1", bus.winner, bus.game_over);
      end
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      modelReset();
      checks++;
      if ({bus.cursor_col, bus.player, bus.winner, bus.game_over} !== {3'(mCursor), 1'b0, 2'b00, 1'b0}) begin
         failures++;
         $display("FAIL draw_restart got cur=%0d pl=%0b win=%0d go=%0b", bus.cursor_col,
                  bus.player, bus.winner, bus.game_over);
      end
   endtask

`ifdef TURN_TIMER_EN
   task automatic test_timer();
      int early, col, row;
      for (int i = 0; i < ROWS; i++) doMove(3, 1'b0, 0);
      early = 0;
      for (int i = 0; i < TC - 1; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         if (bus.turn_timeout !== 1'b0 || bus.wr_en !== 1'b0) early++;
      end
      checks++;
      if (early != 0) begin
         failures++;
         $display("FAIL timer_early got=%0d exp=0", early);
      end
      col = (mCursor + 1) % COLS;
      while (mH[col] >= ROWS) col = (col + 1) % COLS;
      row = mH[col];
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({bus.turn_timeout, bus.wr_en, bus.wr_col, bus.wr_row, bus.wr_player} !==
          {1'b1, 1'b1, 3'(col), 3'(row), 1'(mPlayer)}) begin
         failures++;
         $display("FAIL forced_drop got to=%0b en=%0b col=%0d row=%0d exp to=1 en=1 col=%0d row=%0d",
                  bus.turn_timeout, bus.wr_en, bus.wr_col, bus.wr_row, col, row);
      end
      mH[col]++;
      mMoves++;
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.turn_timeout !== 1'b0) begin
         failures++;
         $display("FAIL timeout_pulse got=%0b exp=0", bus.turn_timeout);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      mPlayer = 1 - mPlayer;
      checks++;
      if (bus.player !== 1'(mPlayer) || bus.cursor_col !== 3'(mCursor)) begin
         failures++;
         $display("FAIL timer_next got pl=%0b cur=%0d exp pl=%0d cur=%0d",
                  bus.player, bus.cursor_col, mPlayer, mCursor);
      end
   endtask
`endif

   task automatic test_abort();
      moveTo(2);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.wr_en !== 1'b1) begin
         failures++;
         $display("FAIL abort_setup got en=%0b exp=1", bus.wr_en);
      end
      #2 reset_n = 1'b0;
      #1;
      modelReset();
      checks++;
      if (bus.wr_en !== 1'b0 || bus.cursor_col !== 3'(mCursor) || bus.player !== 1'b0) begin
         failures++;
         $display("FAIL async_abort got en=%0b cur=%0d pl=%0b exp en=0 cur=%0d pl=0",
                  bus.wr_en, bus.cursor_col, bus.player, mCursor);
      end
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.wr_en !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_write got=%0b exp=0", bus.wr_en);
      end
      doMove(2, 1'b0, 0);
   endtask

   initial begin
      bus.press_izq  = 1'b0;
      bus.press_der  = 1'b0;
      bus.press_ent  = 1'b0;
      bus.check_done = 1'b0;
      bus.check_win  = 1'b0;
      test_reset();
      test_cursor();
      test_drops();
      test_full_column();
      test_win();
      test_draw();
`ifdef TURN_TIMER_EN
      test_timer();
`endif
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
